// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: default field widths,
// forwarding-select codes and the per-stage timing record.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned T_W_DEF   = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  typedef struct packed {
    logic [REG_W_DEF-1:0] r_use1;
    logic [REG_W_DEF-1:0] r_use2;
    logic [REG_W_DEF-1:0] r_new;
    logic [T_W_DEF-1:0]   t_new;
  } stage_rec_t;

  // One pipeline step closer to the result, never below zero.
  function automatic logic [T_W_DEF-1:0] t_dec(input logic [T_W_DEF-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage timing tuple in, stall and forwarding selects out.
// Optional MDU interlock signals exist only when HAZARD_MDU_STALL_EN is defined.
interface hazard_ctrl_if #(
  parameter int unsigned REG_W = hazard_pkg::REG_W_DEF,
  parameter int unsigned T_W   = hazard_pkg::T_W_DEF
);
  logic [REG_W-1:0] d_r_new;
  logic [T_W-1:0]   d_t_new;
  logic [REG_W-1:0] d_r_use1;
  logic [REG_W-1:0] d_r_use2;
  logic [T_W-1:0]   d_t_use1;
  logic [T_W-1:0]   d_t_use2;
`ifdef HAZARD_MDU_STALL_EN
  logic             d_is_md;
  logic             md_busy;
`endif
  logic             stall;
  logic [1:0]       fwd_d_rs;
  logic [1:0]       fwd_d_rt;
  logic [1:0]       fwd_e_rs;
  logic [1:0]       fwd_e_rt;
  logic [1:0]       fwd_m_rt;

  modport master (
    output d_r_new, d_t_new, d_r_use1, d_r_use2, d_t_use1, d_t_use2,
`ifdef HAZARD_MDU_STALL_EN
    output d_is_md, md_busy,
`endif
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  d_r_new, d_t_new, d_r_use1, d_r_use2, d_t_use1, d_t_use2,
`ifdef HAZARD_MDU_STALL_EN
    input  d_is_md, md_busy,
`endif
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );
endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record: bubble insertion, sync clear, and t_new aging.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  // Capture the upstream record, aging its remaining latency by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      q <= '0;
    end else begin
      q <= '{r_use1: d.r_use1, r_use2: d.r_use2, r_new: d.r_new, t_new: t_dec(d.t_new)};
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks destination/latency through E, M, W and
// produces the D-stage stall plus all forwarding selects.
// Build option: HAZARD_MDU_STALL_EN adds the multiply/divide busy interlock.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned T_W   = T_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hif
);

  stage_rec_t       d_rec, m_in, w_in, e_q, m_q, w_q;
  logic [REG_W-1:0] d_rs, d_rt, e_rs, e_rt, m_rt;
  logic [T_W-1:0]   d_tu1, d_tu2;
  logic             stall_c;
  logic             unused_rec;

  // True when stage s will not have register r ready by the cycle it is needed.
  function automatic logic late(input stage_rec_t s, input logic [REG_W_DEF-1:0] r,
                                input logic [T_W_DEF-1:0] t_use);
    return (r != '0) && (s.r_new == r) && (s.t_new > t_use);
  endfunction

  // Nearest producer wins; a nearer producer that is not ready masks older ones.
  function automatic logic [1:0] sel_mw(input logic [REG_W_DEF-1:0] r,
                                        input stage_rec_t m, input stage_rec_t w);
    if (r == '0)                       return FWD_RF;
    if (m.r_new == r)                  return (m.t_new == '0) ? FWD_M : FWD_RF;
    if (w.r_new == r && w.t_new == '0) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] sel_w(input logic [REG_W_DEF-1:0] r, input stage_rec_t w);
    return (r != '0 && w.r_new == r && w.t_new == '0) ? FWD_W : FWD_RF;
  endfunction

  assign d_rs  = hif.d_r_use1;
  assign d_rt  = hif.d_r_use2;
  assign d_tu1 = hif.d_t_use1;
  assign d_tu2 = hif.d_t_use2;
  assign d_rec = '{r_use1: hif.d_r_use1, r_use2: hif.d_r_use2,
                   r_new: hif.d_r_new, t_new: hif.d_t_new};
  assign m_in  = '{r_use1: '0, r_use2: e_q.r_use2, r_new: e_q.r_new, t_new: e_q.t_new};
  assign w_in  = '{r_use1: '0, r_use2: '0, r_new: m_q.r_new, t_new: m_q.t_new};
  assign e_rs  = e_q.r_use1;
  assign e_rt  = e_q.r_use2;
  assign m_rt  = m_q.r_use2;

  assign unused_rec = ^{m_q.r_use1, w_q.r_use1, w_q.r_use2};

  hazard_stage_reg u_e (.clk(clk), .rst_n(rst_n), .bubble(stall_c), .d(d_rec), .q(e_q));
  hazard_stage_reg u_m (.clk(clk), .rst_n(rst_n), .bubble(1'b0),    .d(m_in),  .q(m_q));
  hazard_stage_reg u_w (.clk(clk), .rst_n(rst_n), .bubble(1'b0),    .d(w_in),  .q(w_q));

  // Stall when an E/M producer cannot deliver in time; W is always in time.
  always_comb begin
    stall_c = late(e_q, d_rs, d_tu1) || late(m_q, d_rs, d_tu1) ||
              late(e_q, d_rt, d_tu2) || late(m_q, d_rt, d_tu2);
`ifdef HAZARD_MDU_STALL_EN
    stall_c = stall_c || (hif.d_is_md && hif.md_busy);
`endif
  end

  // Drive stall and forwarding selects for D, E and M consumers.
  always_comb begin
    hif.stall    = stall_c;
    hif.fwd_d_rs = sel_mw(d_rs, m_q, w_q);
    hif.fwd_d_rt = sel_mw(d_rt, m_q, w_q);
    hif.fwd_e_rs = sel_mw(e_rs, m_q, w_q);
    hif.fwd_e_rt = sel_mw(e_rt, m_q, w_q);
    hif.fwd_m_rt = sel_w(m_rt, w_q);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus
// randomized traffic against an instruction-history reference model.
// Build option: HAZARD_MDU_STALL_EN enables the MDU interlock checks.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hif ();
  hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hif(hif.slave));

  // Reference: hist[k] is the D tuple of the instruction that left D k+1 cycles
  // ago (k=0 -> E, 1 -> M, 2 -> W); latency left is its D-relative count minus age.
  typedef struct { int rn; int tn; int u1; int u2; } instr_t;
  instr_t hist [3];

  function automatic int rem(input int k);
    return (hist[k].tn > k + 1) ? hist[k].tn - k - 1 : 0;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    int u [2];
    int tu [2];
    u[0] = int'(hif.d_r_use1); tu[0] = int'(hif.d_t_use1);
    u[1] = int'(hif.d_r_use2); tu[1] = int'(hif.d_t_use2);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++)
        if (u[i] != 0 && hist[k].rn == u[i] && rem(k) > tu[i]) s = 1;
`ifdef HAZARD_MDU_STALL_EN
    if (hif.d_is_md && hif.md_busy) s = 1;
`endif
    return s;
  endfunction

  function automatic int m_fwd(input int r, input int first_k);
    if (r == 0) return 0;
    for (int k = first_k; k < 3; k++)
      if (hist[k].rn == r) return (rem(k) == 0) ? k : 0;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
  endtask

  // Advance one clock; the model steps using the inputs present at the edge.
  task automatic tick();
    bit st;
    @(posedge clk);
    st = m_stall();
    if (!rst_n) model_clear();
    else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (st) hist[0] = '{0, 0, 0, 0};
      else hist[0] = '{int'(hif.d_r_new), int'(hif.d_t_new), int'(hif.d_r_use1), int'(hif.d_r_use2)};
    end
    @(negedge clk);
  endtask

  task automatic drive(input int rn, input int tn, input int u1, input int tu1,
                       input int u2, input int tu2);
    hif.d_r_new  = 5'(rn);
    hif.d_t_new  = 2'(tn);
    hif.d_r_use1 = 5'(u1);
    hif.d_t_use1 = 2'(tu1);
    hif.d_r_use2 = 5'(u2);
    hif.d_t_use2 = 2'(tu2);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs: got stall=%b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d m_rt=%0d want all 0",
               hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 3, 0, 0, 0, 0);           // lw $1
    tick();
    drive(4, 2, 1, 1, 0, 0);           // addu $4, $1
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL load_use_stall: got %b want 1", hif.stall); end
    tick();
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL load_use_release: got %b want 0", hif.stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (hif.fwd_e_rs !== 2'd2) begin bad++; $display("FAIL load_use_fwd_e_rs: got %0d want 2", hif.fwd_e_rs); end
  endtask

  task automatic test_branch_fwd();
    do_reset();
    drive(3, 2, 0, 0, 0, 0);           // addu $3
    tick();
    drive(0, 0, 3, 0, 0, 0);           // beq $3
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL branch_stall: got %b want 1", hif.stall); end
    tick();
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL branch_release: got %b want 0", hif.stall); end
    total++;
    if (hif.fwd_d_rs !== 2'd1) begin bad++; $display("FAIL branch_fwd_d_rs: got %0d want 1", hif.fwd_d_rs); end
  endtask

  task automatic test_store_fwd();
    do_reset();
    drive(2, 2, 0, 0, 0, 0);           // ori $2
    tick();
    drive(0, 0, 0, 1, 2, 2);           // sw $2
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL store_no_stall: got %b want 0", hif.stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    total++;
    if (hif.fwd_e_rt !== 2'd1) begin bad++; $display("FAIL store_fwd_e_rt: got %0d want 1", hif.fwd_e_rt); end
    tick();
    total++;
    if (hif.fwd_m_rt !== 2'd2) begin bad++; $display("FAIL store_fwd_m_rt: got %0d want 2", hif.fwd_m_rt); end
    total++;
    if (hif.fwd_e_rt !== 2'd0) begin bad++; $display("FAIL store_fwd_e_rt_after: got %0d want 0", hif.fwd_e_rt); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(0, 3, 0, 0, 0, 0);           // lw $0
    tick();
    drive(0, 2, 0, 1, 0, 1);           // addu reading $0
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt} !== 11'b0) begin
        bad++;
        $display("FAIL reg_zero_c%0d: got stall=%b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d m_rt=%0d want all 0", c,
                 hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(5, 3, 0, 0, 0, 0);           // lw $5
    tick();
    drive(6, 2, 5, 1, 5, 1);           // dependent addu
    total++;
    if (hif.stall !== 1'b1) begin bad++; $display("FAIL midstall_pre: got %b want 1", hif.stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if ({hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt} !== 11'b0) begin
      bad++;
      $display("FAIL midstall_after_reset: got stall=%b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d m_rt=%0d want all 0",
               hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    total++;
    if ({hif.stall, hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt} !== 11'b0) begin
      bad++;
      $display("FAIL midstall_records_empty: got stall=%b e_rs=%0d e_rt=%0d m_rt=%0d want all 0",
               hif.stall, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt);
    end
  endtask

`ifdef HAZARD_MDU_STALL_EN
  task automatic test_mdu();
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    hif.md_busy = 1'b1;
    hif.d_is_md = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (hif.stall !== 1'b1) begin bad++; $display("FAIL mdu_busy_c%0d: got %b want 1", c, hif.stall); end
      tick();
    end
    hif.md_busy = 1'b0;
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL mdu_idle: got %b want 0", hif.stall); end
    hif.md_busy = 1'b1;
    hif.d_is_md = 1'b0;
    #1;
    total++;
    if (hif.stall !== 1'b0) begin bad++; $display("FAIL mdu_not_md: got %b want 0", hif.stall); end
    hif.md_busy = 1'b0;
  endtask
`endif

  task automatic test_random();
    int e_stall, e_drs, e_drt, e_ers, e_ert, e_mrt;
    do_reset();
    model_clear();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3));
`ifdef HAZARD_MDU_STALL_EN
      hif.d_is_md = 1'($urandom_range(0, 1));
      hif.md_busy = ($urandom_range(0, 3) == 0);
      #1;
`endif
      e_stall = int'(m_stall());
      e_drs = m_fwd(int'(hif.d_r_use1), 1);
      e_drt = m_fwd(int'(hif.d_r_use2), 1);
      e_ers = m_fwd(hist[0].u1, 1);
      e_ert = m_fwd(hist[0].u2, 1);
      e_mrt = m_fwd(hist[1].u2, 2);
      total++;
      if (int'(hif.stall) !== e_stall) begin
        bad++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, hif.stall, e_stall);
      end
      total++;
      if (int'(hif.fwd_d_rs) !== e_drs || int'(hif.fwd_d_rt) !== e_drt) begin
        bad++; $display("FAIL rnd_fwd_d c%0d: got rs=%0d rt=%0d want rs=%0d rt=%0d", c,
                        hif.fwd_d_rs, hif.fwd_d_rt, e_drs, e_drt);
      end
      total++;
      if (int'(hif.fwd_e_rs) !== e_ers || int'(hif.fwd_e_rt) !== e_ert) begin
        bad++; $display("FAIL rnd_fwd_e c%0d: got rs=%0d rt=%0d want rs=%0d rt=%0d", c,
                        hif.fwd_e_rs, hif.fwd_e_rt, e_ers, e_ert);
      end
      total++;
      if (int'(hif.fwd_m_rt) !== e_mrt) begin
        bad++; $display("FAIL rnd_fwd_m_rt c%0d: got %0d want %0d", c, hif.fwd_m_rt, e_mrt);
      end
      tick();
    end
    rst_n = 1'b1;
`ifdef HAZARD_MDU_STALL_EN
    hif.d_is_md = 1'b0;
    hif.md_busy = 1'b0;
`endif
  endtask

  initial begin
`ifdef HAZARD_MDU_STALL_EN
    hif.d_is_md = 1'b0;
    hif.md_busy = 1'b0;
`endif
    model_clear();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_fwd();
    test_store_fwd();
    test_reg_zero();
    test_reset_mid_stall();
`ifdef HAZARD_MDU_STALL_EN
    test_mdu();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
